// File: rtl/counter_pkg.sv
// Shared definitions for the multimode counter: mode encodings and the
// Gray/seed helper functions used by the top and the next-state logic.
package counter_pkg;

  localparam int unsigned MODE_W   = 3;
  localparam int unsigned MAX_FN_W = 32;

  localparam logic [MODE_W-1:0] MODE_UP      = 3'd0;
  localparam logic [MODE_W-1:0] MODE_DOWN    = 3'd1;
  localparam logic [MODE_W-1:0] MODE_GRAY    = 3'd2;
  localparam logic [MODE_W-1:0] MODE_RING    = 3'd3;
  localparam logic [MODE_W-1:0] MODE_JOHNSON = 3'd4;
  localparam logic [MODE_W-1:0] MODE_HOLD    = 3'd5;

  function automatic logic [MAX_FN_W-1:0] bin2gray(input logic [MAX_FN_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Ring starts with its LSB set so the single token has something to rotate.
  function automatic logic [MAX_FN_W-1:0] seed(input logic [MODE_W-1:0] mode,
                                               input int unsigned width);
    logic [MAX_FN_W-1:0] mask;
    mask = (width >= MAX_FN_W) ? '1 : ((MAX_FN_W'(1) << width) - MAX_FN_W'(1));
    return ((mode == MODE_RING) ? MAX_FN_W'(1) : MAX_FN_W'(0)) & mask;
  endfunction

endpackage

// File: rtl/cnt_next_state.sv
// Combinational count step and terminal-count decode for the multimode counter.
// Purely a function of the registered mode, binary state and output pattern.
module cnt_next_state
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = (2**WIDTH) - 1
) (
  input  logic [MODE_W-1:0] mode_q,
  input  logic [WIDTH-1:0]  bin,
  input  logic [WIDTH-1:0]  count,
  input  logic              en,
  output logic [WIDTH-1:0]  bin_nxt_c,
  output logic [WIDTH-1:0]  count_nxt_c,
  output logic              tc_c
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] JOHNSON_TC = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    bin_nxt_c   = bin;
    count_nxt_c = count;
    tc_c        = 1'b0;
    case (mode_q)
      MODE_UP: begin
        bin_nxt_c   = (bin == MAX_W) ? '0 : bin + WIDTH'(1);
        count_nxt_c = bin_nxt_c;
        tc_c        = en && (bin == MAX_W);
      end
      MODE_DOWN: begin
        bin_nxt_c   = (bin == '0) ? MAX_W : bin - WIDTH'(1);
        count_nxt_c = bin_nxt_c;
        tc_c        = en && (bin == '0);
      end
      // Gray output is encoded from the next binary value so it never lags.
      MODE_GRAY: begin
        bin_nxt_c   = (bin == MAX_W) ? '0 : bin + WIDTH'(1);
        count_nxt_c = WIDTH'(bin2gray(MAX_FN_W'(bin_nxt_c)));
        tc_c        = en && (bin == MAX_W);
      end
      MODE_RING: begin
        count_nxt_c = {count[WIDTH-2:0], count[WIDTH-1]};
        bin_nxt_c   = count_nxt_c;
        tc_c        = en && count[WIDTH-1];
      end
      MODE_JOHNSON: begin
        count_nxt_c = {count[WIDTH-2:0], ~count[WIDTH-1]};
        bin_nxt_c   = count_nxt_c;
        tc_c        = en && (count == JOHNSON_TC);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multimode_counter.sv
// Multimode counter: up/down/Gray/ring/Johnson with modulo wrap, clear, load
// and terminal count. Holds the registers and the per-edge priority chain.
module multimode_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = (2**WIDTH) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              le,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  count,
  output logic [WIDTH-1:0]  bin,
  output logic              tc
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_d;
  logic [WIDTH-1:0]  count_d;
  logic [WIDTH-1:0]  bin_d;
  logic [WIDTH-1:0]  step_bin_c;
  logic [WIDTH-1:0]  step_count_c;
  logic [WIDTH-1:0]  din_clamp_c;

  cnt_next_state #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .mode_q      (mode_q),
    .bin         (bin),
    .count       (count),
    .en          (en),
    .bin_nxt_c   (step_bin_c),
    .count_nxt_c (step_count_c),
    .tc_c        (tc)
  );

  assign din_clamp_c = (din > MAX_W) ? MAX_W : din;

  // Priority: mode change > clr > le > en > hold.
  always_comb begin
    mode_d  = mode_q;
    count_d = count;
    bin_d   = bin;
    if (mode != mode_q) begin
      mode_d  = mode;
      count_d = WIDTH'(seed(mode, WIDTH));
      bin_d   = count_d;
    end else if (clr) begin
      count_d = WIDTH'(seed(mode_q, WIDTH));
      bin_d   = count_d;
    end else if (le && (mode_q < MODE_HOLD)) begin
      case (mode_q)
        MODE_RING: begin
          count_d = (din == '0) ? WIDTH'(1) : din;
          bin_d   = count_d;
        end
        MODE_JOHNSON: begin
          count_d = din;
          bin_d   = din;
        end
        MODE_GRAY: begin
          bin_d   = din_clamp_c;
          count_d = WIDTH'(bin2gray(MAX_FN_W'(din_clamp_c)));
        end
        default: begin
          bin_d   = din_clamp_c;
          count_d = din_clamp_c;
        end
      endcase
    end else if (en) begin
      count_d = step_count_c;
      bin_d   = step_bin_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_UP;
      count  <= '0;
      bin    <= '0;
    end else begin
      mode_q <= mode_d;
      count  <= count_d;
      bin    <= bin_d;
    end
  end

endmodule

// File: tb/tb_multimode_counter.sv
// Directed bench for multimode_counter: one DUT with MAX_VAL=9, one full-range.
module tb_multimode_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic       le;
  logic [2:0] mode;
  logic [3:0] din;
  logic [3:0] count9, bin9, count15, bin15;
  logic       tc9, tc15;

  int tests_run;
  int tests_failed;

  multimode_counter #(.WIDTH(4), .MAX_VAL(9)) u_dut9 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .le(le), .mode(mode),
    .din(din), .count(count9), .bin(bin9), .tc(tc9)
  );

  multimode_counter #(.WIDTH(4)) u_dut15 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .le(le), .mode(mode),
    .din(din), .count(count15), .bin(bin15), .tc(tc15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (count9 !== 4'd0 || bin9 !== 4'd0 || count15 !== 4'd0 || bin15 !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got count9=%0d bin9=%0d count15=%0d bin15=%0d expected all 0",
               count9, bin9, count15, bin15);
    end
    tests_run++;
    if (u_dut9.mode_q !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_mode: got %0d expected 0", u_dut9.mode_q);
    end
    @(negedge clk) rst = 1'b0;
    tick();
    tests_run++;
    if (count9 !== 4'd0 || tc9 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: got count=%0d tc=%0b expected 0/0", count9, tc9);
    end
  endtask

  task automatic test_up();
    logic [3:0] exp;
    mode = 3'd0;
    clr  = 1'b1;
    tick();
    clr = 1'b0;
    en  = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      exp = 4'(i % 10);
      tests_run++;
      if (count9 !== exp || bin9 !== exp || tc9 !== (exp == 4'd9)) begin
        tests_failed++;
        $display("FAIL up_step%0d: got count=%0d bin=%0d tc=%0b expected %0d/%0d/%0b",
                 i, count9, bin9, tc9, exp, exp, (exp == 4'd9));
      end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_down();
    logic [3:0] exp;
    mode = 3'd1;
    tick();
    tests_run++;
    if (bin9 !== 4'd0 || tc9 !== 1'b0) begin
      tests_failed++;
      $display("FAIL down_seed: got bin=%0d tc=%0b expected 0/0", bin9, tc9);
    end
    le  = 1'b1;
    din = 4'd12;
    tick();
    le = 1'b0;
    tests_run++;
    if (bin9 !== 4'd9 || count9 !== 4'd9) begin
      tests_failed++;
      $display("FAIL down_load_clamp: got bin=%0d count=%0d expected 9/9", bin9, count9);
    end
    en = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      exp = (i <= 9) ? 4'(9 - i) : 4'd9;
      tests_run++;
      if (count9 !== exp || bin9 !== exp || tc9 !== (exp == 4'd0)) begin
        tests_failed++;
        $display("FAIL down_step%0d: got count=%0d bin=%0d tc=%0b expected %0d/%0d/%0b",
                 i, count9, bin9, tc9, exp, exp, (exp == 4'd0));
      end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_gray();
    logic [3:0] gray_tab [16];
    logic [3:0] prev;
    logic [3:0] exp_bin;
    gray_tab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                 4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    mode = 3'd2;
    tick();
    en   = 1'b1;
    prev = 4'd0;
    for (int i = 0; i <= 16; i++) begin
      exp_bin = 4'(i % 16);
      tests_run++;
      if (bin15 !== exp_bin || count15 !== gray_tab[exp_bin] || tc15 !== (exp_bin == 4'd15)) begin
        tests_failed++;
        $display("FAIL gray_step%0d: got count=%b bin=%0d tc=%0b expected %b/%0d/%0b",
                 i, count15, bin15, tc15, gray_tab[exp_bin], exp_bin, (exp_bin == 4'd15));
      end
      if (i > 0) begin
        tests_run++;
        if ($countones(count15 ^ prev) != 1) begin
          tests_failed++;
          $display("FAIL gray_onebit%0d: got %b -> %b expected one bit change", i, prev, count15);
        end
      end
      prev = count15;
      tick();
    end
    en  = 1'b0;
    le  = 1'b1;
    din = 4'd5;
    tick();
    tests_run++;
    if (bin15 !== 4'd5 || count15 !== 4'b0111) begin
      tests_failed++;
      $display("FAIL gray_load: got bin=%0d count=%b expected 5/0111", bin15, count15);
    end
    din = 4'd12;
    tick();
    le = 1'b0;
    tests_run++;
    if (bin9 !== 4'd9 || count9 !== 4'b1101) begin
      tests_failed++;
      $display("FAIL gray_load_clamp: got bin=%0d count=%b expected 9/1101", bin9, count9);
    end
  endtask

  task automatic test_ring();
    logic [3:0] ring_exp [5];
    logic [3:0] e;
    ring_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    mode = 3'd3;
    tick();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e = ring_exp[i];
      tests_run++;
      if (count15 !== e || bin15 !== e || tc15 !== e[3]) begin
        tests_failed++;
        $display("FAIL ring_step%0d: got count=%b bin=%b tc=%0b expected %b/%b/%0b",
                 i, count15, bin15, tc15, e, e, e[3]);
      end
      tick();
    end
    en  = 1'b0;
    le  = 1'b1;
    din = 4'b0000;
    tick();
    tests_run++;
    if (count15 !== 4'b0001) begin
      tests_failed++;
      $display("FAIL ring_load_zero: got %b expected 0001", count15);
    end
    din = 4'b0101;
    tick();
    le = 1'b0;
    tests_run++;
    if (count15 !== 4'b0101 || bin15 !== 4'b0101) begin
      tests_failed++;
      $display("FAIL ring_load_raw: got count=%b bin=%b expected 0101", count15, bin15);
    end
  endtask

  task automatic test_johnson();
    logic [3:0] j_exp [9];
    logic [3:0] e;
    j_exp = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
              4'b1110, 4'b1100, 4'b1000, 4'b0000};
    mode = 3'd4;
    tick();
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      e = j_exp[i];
      tests_run++;
      if (count15 !== e || bin15 !== e || tc15 !== (e == 4'b1000)) begin
        tests_failed++;
        $display("FAIL johnson_step%0d: got count=%b bin=%b tc=%0b expected %b/%b/%0b",
                 i, count15, bin15, tc15, e, e, (e == 4'b1000));
      end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_simultaneous();
    mode = 3'd0;
    tick();
    le  = 1'b1;
    din = 4'd5;
    tick();
    le = 1'b0;
    tests_run++;
    if (bin9 !== 4'd5) begin
      tests_failed++;
      $display("FAIL simul_preload: got %0d expected 5", bin9);
    end
    clr = 1'b1;
    le  = 1'b1;
    en  = 1'b1;
    din = 4'd3;
    tick();
    clr = 1'b0;
    tests_run++;
    if (bin9 !== 4'd0 || count9 !== 4'd0) begin
      tests_failed++;
      $display("FAIL simul_clr_wins: got bin=%0d count=%0d expected 0/0", bin9, count9);
    end
    le = 1'b1;
    din = 4'd5;
    tick();
    mode = 3'd1;
    din  = 4'd7;
    tick();
    tests_run++;
    if (bin9 !== 4'd0 || count9 !== 4'd0 || u_dut9.mode_q !== 3'd1) begin
      tests_failed++;
      $display("FAIL simul_mode_wins: got bin=%0d count=%0d mode_q=%0d expected 0/0/1",
               bin9, count9, u_dut9.mode_q);
    end
    le = 1'b0;
    en = 1'b0;
    #1;
    tests_run++;
    if (tc9 !== 1'b0) begin
      tests_failed++;
      $display("FAIL tc_needs_en: got %0b expected 0", tc9);
    end
    le  = 1'b1;
    din = 4'd6;
    tick();
    le = 1'b0;
    tick();
    tick();
    tests_run++;
    if (bin9 !== 4'd6 || count9 !== 4'd6) begin
      tests_failed++;
      $display("FAIL hold: got bin=%0d count=%0d expected 6/6", bin9, count9);
    end
  endtask

  task automatic test_async_reset();
    le  = 1'b1;
    din = 4'd7;
    tick();
    le = 1'b0;
    tests_run++;
    if (count9 !== 4'd7) begin
      tests_failed++;
      $display("FAIL arst_preload: got %0d expected 7", count9);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (count9 !== 4'd0 || bin9 !== 4'd0 || u_dut9.mode_q !== 3'd0) begin
      tests_failed++;
      $display("FAIL arst_immediate: got count=%0d bin=%0d mode_q=%0d expected 0/0/0",
               count9, bin9, u_dut9.mode_q);
    end
    mode = 3'd0;
    en   = 1'b1;
    @(negedge clk) rst = 1'b0;
    tick();
    en = 1'b0;
    tests_run++;
    if (count9 !== 4'd1 || bin9 !== 4'd1) begin
      tests_failed++;
      $display("FAIL arst_first_step: got count=%0d bin=%0d expected 1/1", count9, bin9);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst  = 1'b0;
    en   = 1'b0;
    clr  = 1'b0;
    le   = 1'b0;
    mode = 3'd0;
    din  = 4'd0;
    test_reset();
    test_up();
    test_down();
    test_gray();
    test_ring();
    test_johnson();
    test_simultaneous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
